// File: rtl/inference_sequencer.sv
// Frame-level sequencer for one lane-detection inference pass: load, compute, result,
// stretched datapath soft reset, latency counter, error capture and sticky interrupt.
module inference_sequencer #(
    parameter int unsigned NUM_PIXELS        = 131072,
    parameter int unsigned SOFT_RESET_CYCLES = 15,
    parameter int unsigned TIMEOUT_CYCLES    = 16777216,
    parameter int unsigned CNT_WIDTH         = 32
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic                                soft_reset,
    input  logic                                irq_enable,
    input  logic                                irq_clear,
    input  logic                                first_pixel,
    input  logic                                pixel_wr,
    input  logic                                result_valid,
    output logic                                core_rst_n,
    output logic                                busy,
    output logic                                done,
    output logic                                irq,
    output logic [1:0]                          err_code,
    output logic [2:0]                          state,
    output logic [$clog2(NUM_PIXELS + 1)-1:0]   pixel_cnt,
    output logic [CNT_WIDTH-1:0]                cycle_cnt
);

    typedef enum logic [2:0] {
        StIdle    = 3'd0,
        StLoad    = 3'd1,
        StCompute = 3'd2,
        StDone    = 3'd3,
        StError   = 3'd4,
        StSrst    = 3'd5
    } state_e;

    localparam int unsigned PixW  = $clog2(NUM_PIXELS + 1);
    localparam int unsigned SrstW = (SOFT_RESET_CYCLES > 1) ? $clog2(SOFT_RESET_CYCLES) : 1;

    localparam logic [PixW-1:0]      LastPix    = PixW'(NUM_PIXELS - 1);
    localparam logic [CNT_WIDTH-1:0] TimeoutCnt = CNT_WIDTH'(TIMEOUT_CYCLES - 1);
    localparam logic [SrstW-1:0]     SrstLoad   = SrstW'(SOFT_RESET_CYCLES - 1);

    state_e               state_q, state_d;
    logic [SrstW-1:0]     srst_cnt_q;
    logic [PixW-1:0]      pixel_cnt_q;
    logic [CNT_WIDTH-1:0] cycle_cnt_q;
    logic [1:0]           err_code_q;
    logic                 irq_q;
    logic                 core_rst_n_q;

    logic [1:0] err_evt;
    logic       pix_inc;
    logic       frame_start;
    logic       irq_set;
    logic       timeout_hit;

    assign timeout_hit = (cycle_cnt_q == TimeoutCnt);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Errors outrank every other transition; timeout only fires when nothing else does.
    always_comb begin
        state_d     = state_q;
        err_evt     = 2'd0;
        pix_inc     = 1'b0;
        frame_start = 1'b0;
        if (soft_reset) begin
            state_d = StSrst;
        end else begin
            case (state_q)
                StSrst: begin
                    if (srst_cnt_q == '0) state_d = StIdle;
                end
                StIdle, StDone: begin
                    if (first_pixel) begin
                        state_d     = StLoad;
                        frame_start = 1'b1;
                    end
                end
                StLoad: begin
                    if (result_valid) begin
                        err_evt = 2'd1;
                    end else if (first_pixel) begin
                        err_evt = 2'd2;
                    end else if (pixel_wr && pixel_cnt_q == LastPix) begin
                        pix_inc = 1'b1;
                        state_d = StCompute;
                    end else if (timeout_hit) begin
                        err_evt = 2'd3;
                    end else if (pixel_wr) begin
                        pix_inc = 1'b1;
                    end
                end
                StCompute: begin
                    if (pixel_wr || first_pixel) begin
                        err_evt = 2'd2;
                    end else if (result_valid) begin
                        state_d = StDone;
                    end else if (timeout_hit) begin
                        err_evt = 2'd3;
                    end
                end
                StError: state_d = StError;
                default: state_d = StIdle;
            endcase
            if (err_evt != 2'd0) state_d = StError;
        end
    end

    assign irq_set = irq_enable && (state_d != state_q)
                     && (state_d == StDone || state_d == StError);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            core_rst_n_q <= 1'b0;
            srst_cnt_q   <= '0;
            pixel_cnt_q  <= '0;
            cycle_cnt_q  <= '0;
            err_code_q   <= 2'd0;
            irq_q        <= 1'b0;
        end else begin
            core_rst_n_q <= (state_d != StSrst);
            if (soft_reset) begin
                srst_cnt_q <= SrstLoad;
            end else if (state_q == StSrst && srst_cnt_q != '0) begin
                srst_cnt_q <= srst_cnt_q - 1'b1;
            end
            if (state_d == StSrst) begin
                pixel_cnt_q <= '0;
                cycle_cnt_q <= '0;
                err_code_q  <= 2'd0;
                irq_q       <= 1'b0;
            end else begin
                if (frame_start) begin
                    pixel_cnt_q <= PixW'(1);
                    cycle_cnt_q <= '0;
                end else begin
                    if (pix_inc) pixel_cnt_q <= pixel_cnt_q + 1'b1;
                    if (busy && cycle_cnt_q != '1) cycle_cnt_q <= cycle_cnt_q + 1'b1;
                end
                if (err_evt != 2'd0) err_code_q <= err_evt;
                if (irq_set) begin
                    irq_q <= 1'b1;
                end else if (irq_clear) begin
                    irq_q <= 1'b0;
                end
            end
        end
    end

    always_comb begin
        busy  = (state_q == StLoad) || (state_q == StCompute);
        done  = (state_q == StDone);
        state = state_q;
    end

    assign core_rst_n = core_rst_n_q;
    assign irq        = irq_q;
    assign err_code   = err_code_q;
    assign pixel_cnt  = pixel_cnt_q;
    assign cycle_cnt  = cycle_cnt_q;

endmodule
